// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU opcodes and the
// control fields carried from the operand stage into execute.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NREGS      = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALU_OP_W   = 3;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;
   localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b110;
   localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b111;

   typedef struct packed {
      logic [ALU_OP_W-1:0]   alu_op;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
   } ex_ctrl_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, write-first bypass from the writeback port.
module regfile
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = riscv_pkg::XLEN,
   parameter int unsigned NREGS = riscv_pkg::NREGS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2,
   input  logic                  wen,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata
);

   // x0 has no storage; entries 1..NREGS-1 only
   logic [XLEN-1:0] mem [1:NREGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < int'(NREGS); i++) mem[i] <= '0;
      end else begin
         for (int i = 1; i < int'(NREGS); i++) begin
            if (wen && (waddr == REG_ADDR_W'(i))) mem[i] <= wdata;
         end
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      for (int i = 1; i < int'(NREGS); i++) begin
         if (raddr1 == REG_ADDR_W'(i)) rdata1 = mem[i];
         if (raddr2 == REG_ADDR_W'(i)) rdata2 = mem[i];
      end
      // same-cycle writeback wins over the stored value, never for x0
      if (wen && (waddr == raddr1) && (raddr1 != '0)) rdata1 = wdata;
      if (wen && (waddr == raddr2) && (raddr2 != '0)) rdata2 = wdata;
   end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register file read, B operand select
// and a one-entry valid/ready pipeline register feeding the ALU.
module operand_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = riscv_pkg::XLEN,
   parameter int unsigned NREGS = riscv_pkg::NREGS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [REG_ADDR_W-1:0] Rs1,
   input  logic [REG_ADDR_W-1:0] Rs2,
   input  logic [REG_ADDR_W-1:0] Rd,
   input  logic [XLEN-1:0]       ImmExt,
   input  logic                  ALUSrc,
   input  logic [ALU_OP_W-1:0]   ALUControlIn,
   input  logic                  RegWriteIn,
   input  logic                  WbEn,
   input  logic [REG_ADDR_W-1:0] WbAddr,
   input  logic [XLEN-1:0]       WbData,
   input  logic                  Flush,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [XLEN-1:0]       A,
   output logic [XLEN-1:0]       B,
   output logic [ALU_OP_W-1:0]   ALUControl,
   output logic [REG_ADDR_W-1:0] RdOut,
   output logic                  RegWriteOut
);

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] b_sel;
   logic            accept;
   ex_ctrl_t        ctrl_q;

   regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (Rs1),
      .raddr2 (Rs2),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val),
      .wen    (WbEn),
      .waddr  (WbAddr),
      .wdata  (WbData)
   );

   assign b_sel   = ALUSrc ? ImmExt : rs2_val;
   assign InReady = !OutValid || OutReady;
   assign accept  = InValid && InReady && !Flush;

   // captured fields move only on accept so a stalled entry stays bit-stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         OutValid <= 1'b0;
         A        <= '0;
         B        <= '0;
         ctrl_q   <= '0;
      end else if (Flush) begin
         OutValid <= 1'b0;
      end else if (accept) begin
         OutValid <= 1'b1;
         A        <= rs1_val;
         B        <= b_sel;
         ctrl_q   <= '{alu_op: ALUControlIn, rd: Rd, reg_write: RegWriteIn};
      end else if (OutReady) begin
         OutValid <= 1'b0;
      end
   end

   assign ALUControl  = ctrl_q.alu_op;
   assign RdOut       = ctrl_q.rd;
   assign RegWriteOut = ctrl_q.reg_write;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage with hand-computed
// expected values for each vector.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        InValid;
   logic        InReady;
   logic [4:0]  Rs1, Rs2, Rd;
   logic [31:0] ImmExt;
   logic        ALUSrc;
   logic [2:0]  ALUControlIn;
   logic        RegWriteIn;
   logic        WbEn;
   logic [4:0]  WbAddr;
   logic [31:0] WbData;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] A, B;
   logic [2:0]  ALUControl;
   logic [4:0]  RdOut;
   logic        RegWriteOut;

   int checks   = 0;
   int failures = 0;

   operand_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .InValid      (InValid),
      .InReady      (InReady),
      .Rs1          (Rs1),
      .Rs2          (Rs2),
      .Rd           (Rd),
      .ImmExt       (ImmExt),
      .ALUSrc       (ALUSrc),
      .ALUControlIn (ALUControlIn),
      .RegWriteIn   (RegWriteIn),
      .WbEn         (WbEn),
      .WbAddr       (WbAddr),
      .WbData       (WbData),
      .Flush        (Flush),
      .OutValid     (OutValid),
      .OutReady     (OutReady),
      .A            (A),
      .B            (B),
      .ALUControl   (ALUControl),
      .RdOut        (RdOut),
      .RegWriteOut  (RegWriteOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic src,
                        input logic [31:0] imm, input logic [2:0] op, input logic [4:0] rd);
      InValid = 1'b1; Rs1 = r1; Rs2 = r2; ALUSrc = src; ImmExt = imm;
      ALUControlIn = op; Rd = rd; RegWriteIn = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; InValid = 1'b0; Rs1 = '0; Rs2 = '0; Rd = '0; ImmExt = '0;
      ALUSrc = 1'b0; ALUControlIn = '0; RegWriteIn = 1'b0; WbEn = 1'b0;
      WbAddr = '0; WbData = '0; Flush = 1'b0; OutReady = 1'b1;
      #1;
      check("rst_outvalid", 32'(OutValid), 32'd0);
      check("rst_a", A, 32'd0);
      check("rst_b", B, 32'd0);
      check("rst_aluctl", 32'(ALUControl), 32'd0);
      check("rst_rdout", 32'(RdOut), 32'd0);
      check("rst_regwrite", 32'(RegWriteOut), 32'd0);
      check("rst_inready", 32'(InReady), 32'd1);
      step(); step();
      rst_n = 1'b1;

      // write x3 = 7, then read it
      WbEn = 1'b1; WbAddr = 5'd3; WbData = 32'd7;
      step();
      WbEn = 1'b0;
      issue(5'd3, 5'd0, 1'b0, 32'd0, 3'b000, 5'd5);
      step();
      check("wr_outvalid", 32'(OutValid), 32'd1);
      check("wr_a", A, 32'd7);
      check("wr_b", B, 32'd0);
      check("wr_rdout", 32'(RdOut), 32'd5);
      check("wr_regwrite", 32'(RegWriteOut), 32'd1);

      // bypass on rs1 plus immediate select
      WbEn = 1'b1; WbAddr = 5'd4; WbData = 32'h10;
      issue(5'd4, 5'd0, 1'b1, 32'hFFFF_FFFE, 3'b000, 5'd6);
      step();
      check("byp_a", A, 32'h10);
      check("byp_b", B, 32'hFFFF_FFFE);
      check("byp_add", A + B, 32'h0000_000E);
      check("byp_aluctl", 32'(ALUControl), 32'd0);

      // stored x4 read on rs2, no bypass
      WbEn = 1'b0;
      issue(5'd3, 5'd4, 1'b0, 32'd0, 3'b110, 5'd8);
      step();
      check("rs2_a", A, 32'd7);
      check("rs2_b", B, 32'h10);
      check("rs2_aluctl", 32'(ALUControl), 32'd6);

      // x0 writes are discarded, no bypass on x0
      WbEn = 1'b1; WbAddr = 5'd0; WbData = 32'hDEAD;
      issue(5'd0, 5'd0, 1'b0, 32'd0, 3'b001, 5'd9);
      step();
      check("x0_byp_a", A, 32'd0);
      check("x0_byp_b", B, 32'd0);
      WbEn = 1'b0;
      step();
      check("x0_stored_a", A, 32'd0);

      // stall: held entry stays stable while Rs1 moves and x3 is rewritten
      OutReady = 1'b0;
      issue(5'd3, 5'd4, 1'b0, 32'd0, 3'b010, 5'd7);
      #1;
      check("stall_inready", 32'(InReady), 32'd0);
      WbEn = 1'b1; WbAddr = 5'd3; WbData = 32'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         WbEn = 1'b0;
         Rs1 = 5'(3 + i);
         check("stall_valid", 32'(OutValid), 32'd1);
         check("stall_a", A, 32'd0);
         check("stall_b", B, 32'd0);
         check("stall_aluctl", 32'(ALUControl), 32'd1);
         check("stall_rdout", 32'(RdOut), 32'd9);
      end
      OutReady = 1'b1;
      Rs1 = 5'd3;
      #1;
      check("unstall_inready", 32'(InReady), 32'd1);
      step();
      check("unstall_a", A, 32'h55);
      check("unstall_b", B, 32'h10);
      check("unstall_aluctl", 32'(ALUControl), 32'd2);
      check("unstall_rdout", 32'(RdOut), 32'd7);

      // flush drops the incoming instruction, writeback still lands
      Flush = 1'b1;
      WbEn = 1'b1; WbAddr = 5'd6; WbData = 32'h66;
      issue(5'd4, 5'd3, 1'b0, 32'd0, 3'b011, 5'd10);
      step();
      Flush = 1'b0; WbEn = 1'b0; InValid = 1'b0;
      check("flush_valid", 32'(OutValid), 32'd0);
      check("flush_a", A, 32'h55);
      check("flush_b", B, 32'h10);
      check("flush_aluctl", 32'(ALUControl), 32'd2);
      step();
      check("idle_valid", 32'(OutValid), 32'd0);
      issue(5'd6, 5'd0, 1'b0, 32'd0, 3'b100, 5'd11);
      step();
      check("flushwb_valid", 32'(OutValid), 32'd1);
      check("flushwb_a", A, 32'h66);

      // drain with no new instruction
      InValid = 1'b0;
      step();
      check("drain_valid", 32'(OutValid), 32'd0);
      check("drain_a", A, 32'h66);

      // back-to-back throughput
      issue(5'd3, 5'd0, 1'b0, 32'd0, 3'b000, 5'd1);
      step();
      check("b2b0_a", A, 32'h55);
      issue(5'd4, 5'd0, 1'b0, 32'd0, 3'b000, 5'd2);
      step();
      check("b2b1_a", A, 32'h10);
      check("b2b1_valid", 32'(OutValid), 32'd1);
      issue(5'd6, 5'd0, 1'b0, 32'd0, 3'b000, 5'd3);
      step();
      check("b2b2_a", A, 32'h66);
      check("b2b2_rdout", 32'(RdOut), 32'd3);

      // reset during a stall clears everything at once
      InValid = 1'b0; OutReady = 1'b0;
      step();
      check("prerst_valid", 32'(OutValid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(OutValid), 32'd0);
      check("midrst_a", A, 32'd0);
      check("midrst_b", B, 32'd0);
      check("midrst_inready", 32'(InReady), 32'd1);
      step();
      rst_n = 1'b1;
      OutReady = 1'b1;
      issue(5'd5, 5'd3, 1'b0, 32'd0, 3'b101, 5'd12);
      step();
      check("postrst_valid", 32'(OutValid), 32'd1);
      check("postrst_x5", A, 32'd0);
      check("postrst_x3", B, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
# operand_stage

Decode-to-execute operand stage of the RV32 core, directly upstream of `alu`. It holds the 32-entry integer register file. It reads rs1/rs2 with same-cycle writeback bypass and selects B between rs2 and the sign-extended immediate. It registers A, B and ALUControl into a one-entry pipeline register with a valid/ready handshake, stall and flush. The registered outputs drive `alu` directly.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count (address width = clog2(NREGS))

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- InValid  in  1  decoded instruction present
- InReady  out  1  stage can accept this cycle
- Rs1, Rs2, Rd  in  5 each  source/destination register indices
- ImmExt  in  XLEN  sign-extended immediate
- ALUSrc  in  1  0: B=rs2 value, 1: B=ImmExt
- ALUControlIn  in  3  ALU operation code, passed through
- RegWriteIn  in  1  instruction writes Rd
- WbEn  in  1  writeback write enable
- WbAddr  in  5  writeback register index
- WbData  in  XLEN  writeback data
- Flush  in  1  kill held/incoming instruction
- OutValid  out  1  A/B/ALUControl valid to ALU
- OutReady  in  1  execute stage accepts
- A, B  out  XLEN  ALU operands
- ALUControl  out  3  to `alu`
- RdOut  out  5, RegWriteOut  out  1  passed to later stages

## Operation
- Register file: NREGS x XLEN flops; x0 reads 0 always; writes with WbAddr=0 discarded.
- Write: on clk rising edge when WbEn=1 and WbAddr!=0, the entry at WbAddr takes WbData. Writes are independent of the handshake; they land even while stalled or flushed.
- Read: combinational. If WbEn=1, WbAddr==RsN and RsN!=0, the read returns WbData (write-first bypass). Otherwise it returns the stored entry.
- B mux: ALUSrc=1 selects ImmExt, else the rs2 read value. A is always the rs1 read value.
- InReady = !OutValid || OutReady (combinational; no dependence on InValid).
- Accept = InValid && InReady && !Flush. On accept, A, B, ALUControl, RdOut and RegWriteOut capture next cycle and OutValid becomes 1.
- Drain: OutValid && OutReady with no accept sets OutValid to 0 next cycle.
- Hold: OutValid && !OutReady keeps all outputs bit-stable. A later writeback to a captured source does not update the held operands.
- Flush: OutValid goes to 0 next cycle and any incoming instruction that cycle is dropped. Flush overrides accept. Register file writes still occur.
- Captured fields when OutValid=0 are don't-care, but the bench requires they change only on accept.

## Timing
- Reset (rst_n=0, async): all register file entries 0. OutValid=0; A=B=0; ALUControl=0; RdOut=0; RegWriteOut=0. InReady=1 during and after reset.
- Release of rst_n is synchronised externally. First accept is possible on the first edge after release.
- Latency: one cycle from accept to OutValid.
- Throughput: one per cycle when OutReady=1 continuously.
- Reset asserted mid-stall clears OutValid immediately. The held instruction is lost.
- Writeback and read of the same register in one cycle: the new value is captured (bypass).
- Writeback to x0 with a read of x0: reads 0.

## Structure
- Shared package `riscv_pkg`: XLEN, REG_ADDR_W=5, ALU opcode localparams (3'b000 add, etc. — shared with `alu`).
- Sub-module `regfile`: 2R1W, async reset, x0 hardwired, bypass inside. `operand_stage` holds mux + pipeline register.

## Test plan
- Reset: rst_n=0 mid-run with OutValid=1 -> OutValid=0 and A=B=0 immediately; a read of x5 afterward returns 0.
- Write/read: WbEn=1 WbAddr=3 WbData=32'd7, next cycle Rs1=3, Rs2=0, ALUSrc=0, InValid=1 -> next cycle OutValid=1, A=7, B=0.
- Bypass + imm: same cycle WbEn=1 WbAddr=4 WbData=32'h10, Rs1=4, ALUSrc=1, ImmExt=32'hFFFFFFFE -> A=32'h10, B=32'hFFFFFFFE; feeding `alu` with add gives 32'hE.
- x0: WbEn=1 WbAddr=0 WbData=32'hDEAD, then Rs1=0 -> A=0.
- Stall: OutReady=0 for 3 cycles while InValid=1 with changing Rs1 -> InReady=0 and A/B/ALUControl unchanged. OutReady=1 -> the next instruction is captured one cycle later.
- Flush: Flush=1 with OutValid=1 and InValid=1 -> OutValid=0 next cycle and no capture. A WbEn write the same cycle is visible on a later read.
